des_cbc_ctrl: RTL and testbench
===============================

// Module: des_cbc_ctrl
// PURPOSE
//  Sequential front/back end for the combinational DES core. Accepts 64-bit
//  plaintext blocks on a valid/ready handshake and XORs each with a chaining
//  register (CBC mode). Drives the core's PLAIN_TEXT/KEY from registers, holds
//  them SETTLE_CYCLES cycles as a multicycle path, then captures CIPHER_TEXT
//  into a one-entry output buffer with its own valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  4  cycles DES_PT/DES_KEY held stable before DES_CT sampled; legal >=1
//  CNT_W          8  settle counter width; must hold SETTLE_CYCLES-1
// PORTS
//  CLK       in   1   clock, rising edge
//  RST_N     in   1   asynchronous active-low reset
//  KEY       in   64  DES key, sampled on input handshake
//  IV        in   64  initial vector
//  IV_LOAD   in   1   load chain register from IV (IDLE only)
//  IN_VALID  in   1   IN_DATA valid
//  IN_READY  out  1   block accepted when IN_VALID&IN_READY
//  IN_DATA   in   64  plaintext block
//  OUT_VALID out  1   OUT_DATA holds a ciphertext block
//  OUT_READY in   1   consumer takes block when OUT_VALID&OUT_READY
//  OUT_DATA  out  64  ciphertext block
//  DES_PT    out  64  to core PLAIN_TEXT (registered)
//  DES_KEY   out  64  to core KEY (registered)
//  DES_CT    in   64  from core CIPHER_TEXT
//  BUSY      out  1   high while state != IDLE
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, chain=0, DES_PT=0, DES_KEY=0, OUT_DATA=0,
//   OUT_VALID=0, BUSY=0, cnt=0. IN_READY=1 after reset (IV_LOAD low).
//  Reset mid-block: in-flight block and buffered output discarded, chain=0.
//  States: IDLE, SETTLE.
//  IDLE: IN_READY = !IV_LOAD (combinational). IV_LOAD=1 -> chain<=IV; IV_LOAD has
//   priority over IN_VALID in the same cycle. IV_LOAD outside IDLE is ignored.
//  Accept (IDLE, IN_VALID&IN_READY): DES_PT<=IN_DATA^chain, DES_KEY<=KEY,
//   cnt<=SETTLE_CYCLES-1, ->SETTLE. Later KEY/IN_DATA changes have no effect.
//  SETTLE: IN_READY=0, DES_PT/DES_KEY stay constant. cnt decrements to 0.
//   At cnt==0 and (!OUT_VALID | OUT_READY): OUT_DATA<=DES_CT, OUT_VALID<=1,
//   chain<=DES_CT, ->IDLE. At cnt==0 with output buffer full and not draining:
//   stall in SETTLE, cnt held at 0, no capture.
//  Output buffer: OUT_VALID and OUT_DATA are held until OUT_VALID&OUT_READY.
//   Handshake with no new capture -> OUT_VALID<=0. Handshake and capture in the
//   same cycle -> OUT_VALID stays 1 and OUT_DATA takes the new block (no bubble).
//  Latency: OUT_VALID rises SETTLE_CYCLES edges after the accept edge when
//   the buffer is free. IN_READY rises the same cycle.
//   Throughput: 1 block / (SETTLE_CYCLES+1) cycles.
//  IDLE with OUT_VALID=1 still accepts a new block, so one block is in flight
//   and one is buffered.
//  Widths: XOR is bitwise 64-bit. Bit 63 is DES bit 1, same as the core.
// CONFIGURATION
//  DES_CTRL_ECB_MODE_EN defined: adds input port ECB (1 bit, sampled on accept).
//   ECB=1: DES_PT<=IN_DATA (no XOR), chain not updated at capture.
//   ECB=0: CBC as above.
//  Undefined: port absent, CBC only.
// TESTING (reference model: the DES core instance driven by DES_PT/DES_KEY)
//  1 IV_LOAD IV=0, KEY=133457799BBCDFF1, IN_DATA=0123456789ABCDEF
//    -> DES_PT=0123456789ABCDEF; OUT_DATA=85E813540F0AB405 after 4 cycles.
//  2 Second block, IN_DATA=0123456789ABCDEF, no IV reload
//    -> DES_PT=84CB563386A179EA; OUT_DATA equals core output; chain updated.
//  3 OUT_READY=0 across 3 blocks -> 2nd block stalls in SETTLE, IN_READY=0;
//    OUT_DATA stable; drain -> blocks arrive in order, none lost.
//  4 IV_LOAD and IN_VALID together in IDLE -> IN_READY=0, chain=IV; block
//    accepted next cycle, XORed with the new IV.
//  5 RST_N low at SETTLE cnt=2 -> OUT_VALID=0, DES_PT=0, BUSY=0 immediately;
//    next block is XORed with chain=0.
//  6 SETTLE_CYCLES=1, OUT_READY=1, IN_VALID=1 -> block every 2 cycles;
//    ECB=1 (macro on) -> identical blocks give identical OUT_DATA.

Source files
------------

// File: rtl/des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// des_cbc_ctrl
//   Sequential wrapper around a purely combinational DES core, running it in
//   CBC mode. Plaintext blocks arrive on a valid/ready handshake. Each block is
//   XORed with the chaining register and registered onto des_pt/des_key. Those
//   registers are then held for SETTLE_CYCLES cycles, so the core can be timed
//   as a multicycle path. After that des_ct is captured into a one-entry
//   output buffer, which has its own valid/ready handshake.
//
//   Optional feature: define DES_CTRL_ECB_MODE_EN to add the 'ecb' input. When
//   ecb is set on accept, the block bypasses the XOR and the chain register is
//   left untouched when that block is captured.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   key        in   64  DES key, sampled on input handshake
//   iv         in   64  initial vector
//   iv_load    in   1   load chain register from iv (idle only, beats in_valid)
//   in_valid   in   1   in_data valid
//   in_ready   out  1   block accepted when in_valid & in_ready
//   in_data    in   64  plaintext block
//   out_valid  out  1   out_data holds a ciphertext block
//   out_ready  in   1   consumer takes block when out_valid & out_ready
//   out_data   out  64  ciphertext block
//   des_pt     out  64  to core PLAIN_TEXT (registered)
//   des_key    out  64  to core KEY (registered)
//   des_ct     in   64  from core CIPHER_TEXT
//   ecb        in   1   (DES_CTRL_ECB_MODE_EN only) ECB select, sampled on accept
//   busy       out  1   high while a block is in flight
// -----------------------------------------------------------------------------
module des_cbc_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] key,
    input  logic [63:0] iv,
    input  logic        iv_load,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [63:0] des_pt,
    output logic [63:0] des_key,
    input  logic [63:0] des_ct,
`ifdef DES_CTRL_ECB_MODE_EN
    input  logic        ecb,
`endif
    output logic        busy
);

    typedef enum logic {
        StIdle,
        StSettle
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       chain_q, chain_d;
    logic [63:0]       pt_q, pt_d;
    logic [63:0]       key_q, key_d;
    logic [63:0]       out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    // use_xor: chain the incoming block; upd_chain: the block in flight feeds
    // the chain when captured.
    logic              use_xor;
    logic              upd_chain;

`ifdef DES_CTRL_ECB_MODE_EN
    logic              ecb_q, ecb_d;

    assign use_xor   = !ecb;
    assign upd_chain = !ecb_q;
`else
    assign use_xor   = 1'b1;
    assign upd_chain = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        chain_d     = chain_q;
        pt_d        = pt_q;
        key_d       = key_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef DES_CTRL_ECB_MODE_EN
        ecb_d       = ecb_q;
`endif
        in_ready    = 1'b0;

        // Consumer drain; a capture below in the same cycle overrides this,
        // giving back-to-back output without a bubble.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                in_ready = !iv_load;
                if (iv_load) begin
                    chain_d = iv;
                end else if (in_valid) begin
                    pt_d    = use_xor ? (in_data ^ chain_q) : in_data;
                    key_d   = key;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
`ifdef DES_CTRL_ECB_MODE_EN
                    ecb_d   = ecb;
`endif
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!out_valid_q || out_ready) begin
                    out_data_d  = des_ct;
                    out_valid_d = 1'b1;
                    if (upd_chain) begin
                        chain_d = des_ct;
                    end
                    state_d = StIdle;
                end
                // Otherwise the buffer is full and not draining: hold at cnt 0.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            chain_q     <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef DES_CTRL_ECB_MODE_EN
            ecb_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chain_q     <= chain_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef DES_CTRL_ECB_MODE_EN
            ecb_q       <= ecb_d;
`endif
        end
    end

    assign des_pt    = pt_q;
    assign des_key   = key_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_cbc_ctrl
//   Bench for des_cbc_ctrl. The DES core is stood in for by a keyed mixing
//   function: the controller only moves blocks and does not depend on the
//   cipher itself. The model works at the transaction level. Each accepted
//   block pushes its expected ciphertext onto a queue, and each output
//   handshake pops from that queue and compares. Two instances are used: the
//   default SETTLE_CYCLES=4 and a SETTLE_CYCLES=1 instance for the throughput
//   test.
// -----------------------------------------------------------------------------
module tb_des_cbc_ctrl;

    localparam int unsigned S  = 4;
    localparam int unsigned S1 = 1;

    logic        clk;
    logic        rst_n;
    logic [63:0] key, iv, in_data, out_data, des_pt, des_key, des_ct;
    logic        iv_load, in_valid, in_ready, out_valid, out_ready, busy;
    logic        ecb_s;

    logic [63:0] f_key, f_iv, f_in_data, f_out_data, f_des_pt, f_des_key, f_des_ct;
    logic        f_iv_load, f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_busy;
    logic        f_ecb;

    int          checks;
    int          errors;

    logic [63:0] chain_m;
    logic [63:0] last_pt_m;
    logic [63:0] exp_q[$];
    logic        last_acc;
    logic        rnd_rdy;

    logic [63:0] f_chain;
    logic [63:0] f_q[$];

    function automatic logic [63:0] core_f(input logic [63:0] pt, input logic [63:0] k);
        logic [63:0] x;
        x = (pt ^ {k[31:0], k[63:32]}) * 64'h9E37_79B9_7F4A_7C15;
        return x ^ (x >> 29) ^ k;
    endfunction

    assign des_ct   = core_f(des_pt, des_key);
    assign f_des_ct = core_f(f_des_pt, f_des_key);

    des_cbc_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .iv        (iv),
        .iv_load   (iv_load),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .des_pt    (des_pt),
        .des_key   (des_key),
        .des_ct    (des_ct),
`ifdef DES_CTRL_ECB_MODE_EN
        .ecb       (ecb_s),
`endif
        .busy      (busy)
    );

    des_cbc_ctrl #(.SETTLE_CYCLES(S1), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (f_key),
        .iv        (f_iv),
        .iv_load   (f_iv_load),
        .in_valid  (f_in_valid),
        .in_ready  (f_in_ready),
        .in_data   (f_in_data),
        .out_valid (f_out_valid),
        .out_ready (f_out_ready),
        .out_data  (f_out_data),
        .des_pt    (f_des_pt),
        .des_key   (f_des_key),
        .des_ct    (f_des_ct),
`ifdef DES_CTRL_ECB_MODE_EN
        .ecb       (f_ecb),
`endif
        .busy      (f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [63:0] d, input logic [63:0] k);
        logic [63:0] o;
        last_pt_m = ecb_s ? d : (d ^ chain_m);
        o = core_f(last_pt_m, k);
        exp_q.push_back(o);
        if (!ecb_s) chain_m = o;
    endtask

    // One clock: sample handshakes just before the edge, update the model,
    // then step to 2 time units after the next rising edge.
    task automatic cycle();
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        #1;
        last_acc = in_valid && in_ready;
        if (iv_load) chain_m = iv;
        if (last_acc) model_accept(in_data, key);
        if (out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL out_extra observed=%h expected=none", out_data);
            end
            if (exp_q.size() != 0) chk("out_data", out_data, exp_q.pop_front());
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] k);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        key      = k;
        for (int n = 0; n < 100 && !done; n++) begin
            cycle();
            done = last_acc;
        end
        in_valid = 1'b0;
        in_data  = 64'h0;
        key      = 64'h0;
        chk("send_accepted", {63'b0, done}, 64'd1);
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        f_q.delete();
        chain_m = 64'h0;
        f_chain = 64'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Throughput instance: hold inputs, count accepts, check every output.
    task automatic f_run(input int n, output int acc);
        logic [63:0] o;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            if (f_out_valid && f_out_ready) begin
                checks++;
                assert (f_q.size() != 0)
                else begin
                    errors++;
                    $error("FAIL f_out_extra observed=%h expected=none", f_out_data);
                end
                if (f_q.size() != 0) chk("f_out_data", f_out_data, f_q.pop_front());
            end
            if (f_in_valid && f_in_ready) begin
                acc++;
                o = core_f(f_ecb ? f_in_data : (f_in_data ^ f_chain), f_key);
                f_q.push_back(o);
                if (!f_ecb) f_chain = o;
            end
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [63:0] hold;
        logic [63:0] r_iv, r_d;
        int          lat;
        int          acc;

        checks    = 0;
        errors    = 0;
        rnd_rdy   = 1'b0;
        rst_n     = 1'b1;
        key       = '0;
        iv        = '0;
        iv_load   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        ecb_s     = 1'b0;
        f_key     = '0;
        f_iv      = '0;
        f_iv_load = 1'b0;
        f_in_valid = 1'b0;
        f_in_data = '0;
        f_out_ready = 1'b0;
        f_ecb     = 1'b0;
        chain_m   = '0;
        last_pt_m = '0;
        f_chain   = '0;
        #3;
        do_reset();

        // Reset state
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_des_pt", des_pt, 64'd0);
        chk("rst_des_key", des_key, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        #1;
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);

        // Test 1: IV=0 load, then first block, latency and des_pt
        iv_load = 1'b1;
        iv      = 64'h0;
        #1;
        chk("ivload_in_ready", {63'b0, in_ready}, 64'd0);
        cycle();
        iv_load   = 1'b0;
        out_ready = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1);
        chk("t1_des_pt", des_pt, 64'h0123_4567_89AB_CDEF);
        chk("t1_des_key", des_key, 64'h1334_5779_9BBC_DFF1);
        chk("t1_busy", {63'b0, busy}, 64'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("t1_pt_stable", des_pt, 64'h0123_4567_89AB_CDEF);
            cycle();
            lat++;
        end
        chk("t1_latency", 64'(lat), 64'(S));
        chk("t1_in_ready_back", {63'b0, in_ready}, 64'd1);
        wait_drain();

        // Test 2: second block chained off the first ciphertext
        send(64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1);
        chk("t2_des_pt", des_pt, last_pt_m);
        wait_drain();

        // Test 3: output backpressure across three blocks
        out_ready = 1'b0;
        send(64'hAAAA_0000_1111_2222, 64'h0F0F_0F0F_0F0F_0F0F);
        for (int n = 0; n < 20 && !out_valid; n++) cycle();
        chk("t3_first_valid", {63'b0, out_valid}, 64'd1);
        hold = out_data;
        send(64'hBBBB_3333_4444_5555, 64'h0F0F_0F0F_0F0F_0F0F);
        for (int n = 0; n < 8; n++) cycle();
        #1;
        chk("t3_stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("t3_stall_busy", {63'b0, busy}, 64'd1);
        chk("t3_stall_out_valid", {63'b0, out_valid}, 64'd1);
        chk("t3_out_stable", out_data, hold);
        chk("t3_out_first", out_data, exp_q[0]);
        out_ready = 1'b1;
        send(64'hCCCC_6666_7777_8888, 64'h0F0F_0F0F_0F0F_0F0F);
        wait_drain();

        // Test 4: iv_load and in_valid together; iv wins, block follows
        r_iv     = {$urandom, $urandom};
        r_d      = {$urandom, $urandom};
        iv_load  = 1'b1;
        iv       = r_iv;
        in_valid = 1'b1;
        in_data  = r_d;
        key      = 64'h5555_AAAA_5555_AAAA;
        #1;
        chk("t4_in_ready_low", {63'b0, in_ready}, 64'd0);
        cycle();
        iv_load = 1'b0;
        send(r_d, 64'h5555_AAAA_5555_AAAA);
        chk("t4_des_pt", des_pt, r_d ^ r_iv);
        wait_drain();

        // Test 5: asynchronous reset while settling at cnt=2
        send({$urandom, $urandom}, {$urandom, $urandom});
        cycle();
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", {63'b0, out_valid}, 64'd0);
        chk("t5_des_pt", des_pt, 64'd0);
        chk("t5_busy", {63'b0, busy}, 64'd0);
        exp_q.delete();
        f_q.delete();
        chain_m = 64'h0;
        f_chain = 64'h0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        r_d = {$urandom, $urandom};
        send(r_d, 64'h1234_5678_9ABC_DEF0);
        chk("t5_chain_zero", des_pt, r_d);
        wait_drain();

        // Randomised traffic with random output backpressure
        rnd_rdy = 1'b1;
        for (int b = 0; b < 16; b++) begin
            send({$urandom, $urandom}, {$urandom, $urandom});
            repeat ($urandom_range(0, 3)) cycle();
        end
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Test 6: SETTLE_CYCLES=1 gives one block every two cycles
        f_in_data   = {$urandom, $urandom};
        f_key       = {$urandom, $urandom};
        f_in_valid  = 1'b1;
        f_out_ready = 1'b1;
        f_run(20, acc);
        chk("t6_throughput", 64'(acc), 64'd10);
        f_in_valid = 1'b0;
        f_run(4, acc);
        chk("t6_drained", 64'(f_q.size()), 64'd0);
`ifdef DES_CTRL_ECB_MODE_EN
        // ECB: identical blocks produce identical ciphertext
        f_ecb      = 1'b1;
        f_in_valid = 1'b1;
        f_run(10, acc);
        f_in_valid = 1'b0;
        f_run(4, acc);
        chk("t6_ecb_out", f_out_data, core_f(f_in_data, f_key));
        chk("t6_ecb_drained", 64'(f_q.size()), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
